// File: rtl/ftdi_pixel_unpacker_if.sv
// rtl/ftdi_pixel_unpacker_if.sv - byte input and framebuffer write bundle for the pixel unpacker
interface ftdi_pixel_unpacker_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              fb_wr_en;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [23:0]       fb_wr_data;
  logic              buf_sel;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output rx_data, rx_valid,
    input  fb_wr_en, fb_wr_addr, fb_wr_data, buf_sel, frame_done, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output fb_wr_en, fb_wr_addr, fb_wr_data, buf_sel, frame_done, frame_err
  );
endinterface

// File: rtl/ftdi_pixel_unpacker.sv
// rtl/ftdi_pixel_unpacker.sv - A5 5A framed RGB byte stream to double-buffered framebuffer writes
module ftdi_pixel_unpacker #(
  parameter int PIXELS  = 4096,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1024
) (
  input logic                   clk_60,
  input logic                   rst,
  ftdi_pixel_unpacker_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC2 = 2'd1,
    PIXEL = 2'd2
  } state_t;

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   PIX_LAST  = (ADDR_W + 1)'(PIXELS - 1);
  localparam logic [7:0]        SYNC_A    = 8'hA5;
  localparam logic [7:0]        SYNC_B    = 8'h5A;

  state_t            state_q;
  logic [1:0]        phase_q;
  logic [ADDR_W:0]   pix_q;
  logic [IDLE_W-1:0] idle_q;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic              fb_wr_en_q;
  logic [ADDR_W-1:0] fb_wr_addr_q;
  logic [23:0]       fb_wr_data_q;
  logic              buf_sel_q;
  logic              frame_done_q;
  logic              frame_err_q;

  logic              idle_expire_d;
  logic [IDLE_W-1:0] idle_d;
  logic [ADDR_W:0]   pix_d;

  // The TIMEOUT-th consecutive idle cycle aborts; a byte in that cycle wins.
  assign idle_expire_d = !bus.rx_valid && (idle_q == IDLE_LAST);
  assign idle_d        = idle_q + IDLE_W'(1);
  assign pix_d         = pix_q + (ADDR_W + 1)'(1);

  always_ff @(posedge clk_60) begin
    if (rst) begin
      state_q      <= HUNT;
      phase_q      <= 2'd0;
      pix_q        <= '0;
      idle_q       <= '0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      fb_wr_en_q   <= 1'b0;
      fb_wr_addr_q <= '0;
      fb_wr_data_q <= 24'd0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      fb_wr_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        HUNT: begin
          idle_q <= '0;
          if (bus.rx_valid && bus.rx_data == SYNC_A) begin
            state_q <= SYNC2;
          end
        end
        SYNC2: begin
          if (bus.rx_valid) begin
            idle_q <= '0;
            if (bus.rx_data == SYNC_B) begin
              state_q <= PIXEL;
              phase_q <= 2'd0;
              pix_q   <= '0;
            end else if (bus.rx_data != SYNC_A) begin
              state_q <= HUNT;
            end
          end else if (idle_expire_d) begin
            state_q     <= HUNT;
            idle_q      <= '0;
            frame_err_q <= 1'b1;
          end else begin
            idle_q <= idle_d;
          end
        end
        PIXEL: begin
          if (bus.rx_valid) begin
            idle_q <= '0;
            case (phase_q)
              2'd0: begin
                r_q     <= bus.rx_data;
                phase_q <= 2'd1;
              end
              2'd1: begin
                g_q     <= bus.rx_data;
                phase_q <= 2'd2;
              end
              default: begin
                phase_q      <= 2'd0;
                fb_wr_en_q   <= 1'b1;
                fb_wr_addr_q <= pix_q[ADDR_W-1:0];
                fb_wr_data_q <= {r_q, g_q, bus.rx_data};
                pix_q        <= pix_d;
                if (pix_q == PIX_LAST) begin
                  state_q      <= HUNT;
                  pix_q        <= '0;
                  frame_done_q <= 1'b1;
                  buf_sel_q    <= ~buf_sel_q;
                end
              end
            endcase
          end else if (idle_expire_d) begin
            state_q     <= HUNT;
            idle_q      <= '0;
            phase_q     <= 2'd0;
            pix_q       <= '0;
            frame_err_q <= 1'b1;
          end else begin
            idle_q <= idle_d;
          end
        end
        default: begin
          state_q <= HUNT;
          idle_q  <= '0;
        end
      endcase
    end
  end

  assign bus.fb_wr_en   = fb_wr_en_q;
  assign bus.fb_wr_addr = fb_wr_addr_q;
  assign bus.fb_wr_data = fb_wr_data_q;
  assign bus.buf_sel    = buf_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: doc/ftdi_pixel_unpacker.md
FTDI_PIXEL_UNPACKER -- requirements
Module: ftdi_pixel_unpacker

Interface
REQ-001 Parameter PIXELS, default 4096: pixels per frame (64x64 panel).
REQ-002 Parameter ADDR_W, default 12: framebuffer address width; PIXELS SHALL be <= 2**ADDR_W.
REQ-003 Parameter TIMEOUT, default 1024: idle clk_60 cycles mid-frame before abort.
REQ-004 clk_60  in  1  60 MHz FTDI clock; the block SHALL have one clock, and all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset; the block SHALL treat it as synchronous and active-high.
REQ-006 rx_data  in  8  byte from the upstream FTDI FIFO reader; valid only when rx_valid=1.
REQ-007 rx_valid  in  1  one-cycle strobe per received byte; the block SHALL accept a byte on any cycle, including back-to-back cycles.
REQ-008 fb_wr_en  out  1  framebuffer write strobe.
REQ-009 fb_wr_addr  out  ADDR_W  pixel index within the frame.
REQ-010 fb_wr_data  out  24  pixel data as {R,G,B}.
REQ-011 buf_sel  out  1  selects the write half of the double buffer; the display side reads ~buf_sel.
REQ-012 frame_done  out  1  one-cycle pulse when a complete frame is written.
REQ-013 frame_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-014 The FSM SHALL have three states: HUNT, SYNC2 and PIXEL.
REQ-015 HUNT: on rx_valid with rx_data=0xA5, the FSM SHALL go to SYNC2; all other bytes SHALL be discarded.
REQ-016 SYNC2: on rx_valid, the FSM SHALL go to PIXEL if the byte is 0x5A, stay in SYNC2 if 0xA5, and otherwise go to HUNT.
REQ-017 On entering PIXEL, the byte phase SHALL be 0 and the pixel counter SHALL be 0.
REQ-018 PIXEL: each rx_valid byte SHALL be latched in order R (phase 0), G (phase 1), B (phase 2); phase SHALL wrap 2->0.
REQ-019 In PIXEL, 0xA5 and 0x5A SHALL be treated as ordinary data; no resync SHALL occur mid-frame.
REQ-020 On the B byte at cycle n, the block SHALL, in cycle n+1, drive fb_wr_en=1 for exactly one cycle, fb_wr_data={R,G,B} and fb_wr_addr=pixel counter; the pixel counter SHALL then increment.
REQ-021 fb_wr_addr and fb_wr_data SHALL hold their last values while fb_wr_en=0.
REQ-022 When the write of pixel PIXELS-1 is issued, the block SHALL, in that same cycle n+1, pulse frame_done, toggle buf_sel and return to HUNT.
REQ-023 After a completed frame, a 0xA5 arriving in cycle n+1 SHALL be evaluated in HUNT.
REQ-024 In SYNC2 and PIXEL, an idle counter SHALL count cycles with rx_valid=0 and clear on every rx_valid.
REQ-025 When the idle counter reaches TIMEOUT, the block SHALL, in the next cycle, pulse frame_err and go to HUNT; buf_sel SHALL NOT toggle, and pixels already written SHALL remain written.
REQ-026 If rx_valid is 1 in the cycle the idle counter would reach TIMEOUT, the byte SHALL be processed and no timeout SHALL occur.
REQ-027 In HUNT, the idle counter SHALL be held at 0.
REQ-028 frame_done and frame_err SHALL never be asserted in the same cycle.
REQ-029 The counter widths SHALL be: phase 2 bits, pixel ADDR_W+1 bits, idle $clog2(TIMEOUT+1) bits; none of them SHALL wrap within a frame.

Reset
REQ-030 With rst=1 at a clock edge, on the next cycle the block SHALL be in state HUNT with phase, pixel counter and idle counter at 0.
REQ-031 On that same cycle, outputs SHALL be fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, buf_sel=0, frame_done=0 and frame_err=0.
REQ-032 rst SHALL take priority over rx_valid.
REQ-033 A rst mid-frame SHALL abort the frame with no frame_done and no frame_err; a write pending from a B byte in the reset cycle SHALL be dropped.

Verification
REQ-034 Sync+pixel, PIXELS=4: bytes A5 5A 11 22 33 -> fb_wr_en one cycle after 0x33, addr=0, data=0x112233.
REQ-035 Full frame, back-to-back bytes, PIXELS=4: A5 5A plus 12 bytes -> writes at addr 0..3 every 3rd cycle, frame_done coincident with the addr-3 write, buf_sel 0->1; a second frame returns buf_sel to 0.
REQ-036 Sync robustness: 00 A5 A5 5A then RGB bytes -> sync accepted and a pixel is written. A5 00 5A then RGB bytes -> no write.
REQ-037 Data-as-sync: pixel bytes A5 5A A5 inside a frame -> written as 0xA55AA5, no resync.
REQ-038 Timeout, TIMEOUT=8: sync, one full pixel, then R only, then 8 idle cycles -> frame_err pulse, buf_sel unchanged, next frame restarts at addr 0.
REQ-039 Reset mid-frame: rst asserted after 2 pixels -> all outputs at reset values, no pulses; a following valid frame starts at addr 0.
